// File: rtl/qam_tx_ctrl.sv
// qam_tx_ctrl: frame sequencer for the QAM transmitter (bit requests, symbol strobes, fill/IF enables, mixer phase, flush)
// Ports: clk, rst (async active-low); start/frame_len request a frame in IDLE; bit_vld marks a valid source bit;
//   bit_req/bit_zero drive the SPC, sym_en strobes the mapper, flush marks zero insertion, usi_en/if_en gate
//   the upsampler and IF register, mix_phase drives the mixer, busy/done/underrun report frame status.
// Optional build macro QAM_TX_CTRL_ABORT_EN adds input abort (ends RUN at the next symbol boundary).
module qam_tx_ctrl #(
  parameter int UPS = 4,
  parameter int FILL_CYC = 8,
  parameter int FLUSH_CYC = 32,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             bit_vld,
  output logic             bit_req,
  output logic             bit_zero,
  output logic             sym_en,
  output logic             flush,
  output logic             usi_en,
  output logic [1:0]       mix_phase,
  output logic             if_en,
  output logic             busy,
  output logic             done,
  output logic             underrun
`ifdef QAM_TX_CTRL_ABORT_EN
  ,
  input  logic             abort
`endif
);
  localparam int PH_W = $clog2(UPS);
  localparam int FI_W = $clog2(FILL_CYC + 1);
  localparam int FL_W = $clog2(FLUSH_CYC + 1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  state_t state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [LEN_W-1:0] sym_q, sym_d, len_q, len_d;
  logic [FI_W-1:0] fill_q, fill_d;
  logic [FL_W-1:0] fl_q, fl_d;
  logic [1:0] mix_q, mix_d;
  logic done_q, done_d, unr_q, unr_d;
  logic go, last_ph, stop, fl_last;
`ifdef QAM_TX_CTRL_ABORT_EN
  logic ab_q, ab_d;
`endif
  assign busy = state_q != S_IDLE;
  assign flush = state_q == S_FLUSH;
  assign bit_req = state_q == S_RUN && ph_q < PH_W'(2);
  assign bit_zero = flush || (bit_req && !bit_vld);
  assign sym_en = busy && ph_q == PH_W'(2);
  assign usi_en = busy && fill_q == FI_W'(FILL_CYC);
  assign if_en = usi_en;
  assign mix_phase = mix_q;
  assign done = done_q;
  assign underrun = unr_q;
  always_comb begin
    go = state_q == S_IDLE && start && frame_len != '0;
    last_ph = ph_q == PH_W'(UPS - 1);
    fl_last = fl_q == FL_W'(FLUSH_CYC - 1);
`ifdef QAM_TX_CTRL_ABORT_EN
    // a pending or same-cycle abort ends the frame once the current symbol completes
    stop = last_ph && (sym_q + LEN_W'(1) == len_q || ab_q || abort);
    ab_d = go ? 1'b0 : ab_q | (state_q == S_RUN && abort);
`else
    stop = last_ph && sym_q + LEN_W'(1) == len_q;
`endif
    state_d = go ? S_RUN
            : (state_q == S_RUN && stop) ? S_FLUSH
            : (state_q == S_FLUSH && fl_last) ? S_IDLE
            : state_q;
    ph_d = go ? '0 : busy ? (last_ph ? '0 : ph_q + PH_W'(1)) : ph_q;
    sym_d = go ? '0 : (state_q == S_RUN && last_ph) ? sym_q + LEN_W'(1) : sym_q;
    len_d = go ? frame_len : len_q;
    fill_d = go ? '0 : (busy && fill_q != FI_W'(FILL_CYC)) ? fill_q + FI_W'(1) : fill_q;
    fl_d = flush ? fl_q + FL_W'(1) : '0;
    mix_d = go ? 2'd0 : busy ? mix_q + 2'd1 : mix_q;
    done_d = flush && fl_last;
    unr_d = go ? 1'b0 : unr_q | (bit_req && !bit_vld);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ph_q <= '0;
      sym_q <= '0;
      len_q <= '0;
      fill_q <= '0;
      fl_q <= '0;
      mix_q <= 2'd0;
      done_q <= 1'b0;
      unr_q <= 1'b0;
`ifdef QAM_TX_CTRL_ABORT_EN
      ab_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      sym_q <= sym_d;
      len_q <= len_d;
      fill_q <= fill_d;
      fl_q <= fl_d;
      mix_q <= mix_d;
      done_q <= done_d;
      unr_q <= unr_d;
`ifdef QAM_TX_CTRL_ABORT_EN
      ab_q <= ab_d;
`endif
    end
  end
endmodule

// File: doc/qam_tx_ctrl.md
# qam_tx_ctrl

Frame sequencer for the single-clock QAM transmitter. It takes a frame-start request and a symbol count, then generates every enable the datapath needs: bit requests to the serial-to-parallel stage, symbol strobes to the signal mapper, and the upsampler fill enable. It also drives the 4-phase mixer counter and the IF output enable, and runs the zero-insertion flush that drains the SRRC delay line. It sits between the frame/bit source and the SPC → SM → USI → SRRC → mixer chain, all on `clk`.

## Interface
- `UPS`, 4: samples per symbol; even, ≥ 4.
- `FILL_CYC`, 8: busy cycles before `usi_en` / `if_en` assert.
- `FLUSH_CYC`, 32: zero-insertion cycles after the last data symbol; ≥ 1.
- `LEN_W`, 12: width of the frame-length field.
- `clk  in  1`: sample clock; all logic is on its rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: frame request, sampled in IDLE only.
- `frame_len  in  LEN_W`: symbol count, latched with `start`.
- `bit_vld  in  1`: the source holds a valid bit this cycle.
- `bit_req  out  1`: the SPC consumes one bit this cycle.
- `bit_zero  out  1`: forces the SPC input to 0 (underrun or flush).
- `sym_en  out  1`: one-cycle SM strobe per symbol.
- `flush  out  1`: flush in progress; the mapper output is replaced by zero symbols.
- `usi_en  out  1`: upsampler/SRRC fill complete.
- `mix_phase  out  2`: mixer phase (0:−Q, 1:−I, 2:Q, 3:I).
- `if_en  out  1`: the IF output register may update.
- `busy  out  1`: frame in progress.
- `done  out  1`: one-cycle end-of-frame pulse.
- `underrun  out  1`: sticky; `bit_req` was high while `bit_vld` was low during this frame.

## Operation
- States: IDLE, RUN, FLUSH.
  - IDLE → RUN when `start`=1 and `frame_len`≠0.
  - RUN → FLUSH after the last sample of symbol `frame_len`.
  - FLUSH → IDLE after `FLUSH_CYC` cycles.
- `start` with `frame_len`=0 is ignored. `start` outside IDLE is ignored.
- Symbol phase counter `ph` runs 0..UPS−1 in RUN and FLUSH. It clears on RUN entry and wraps to 0.
- Symbol counter (LEN_W bits) increments at `ph`=UPS−1 in RUN. When it equals the latched length, the next state is FLUSH.
- `bit_req` = RUN && (`ph`==0 || `ph`==1), giving exactly two bits per symbol.
- `bit_zero` = FLUSH || (`bit_req` && !`bit_vld`). Missing bits are transmitted as 0, never stalled.
- `sym_en` = (RUN || FLUSH) && `ph`==2. Strobes continue through FLUSH so the zero symbols propagate.
- `underrun`:
  - Set when `bit_req` && !`bit_vld`.
  - Cleared on accepted `start`.
  - Held otherwise, including in IDLE.
- A fill counter counts busy cycles and saturates at `FILL_CYC`. `usi_en` = `if_en` = busy && counter==`FILL_CYC`.
- `mix_phase`:
  - Set to 0 on accepted `start`.
  - Increments mod 4 every busy cycle.
  - Holds in IDLE.
- `done` is registered. It pulses in the first IDLE cycle after FLUSH.
- `bit_req`, `bit_zero`, `sym_en`, `flush`, `usi_en`, `if_en` and `busy` decode from registered state only; `bit_zero` additionally uses `bit_vld`.

## Timing
- Reset values:
  - state IDLE.
  - `ph`, symbol count, fill count, `mix_phase`: 0.
  - `done`, `underrun`, `busy`, `bit_req`, `bit_zero`, `sym_en`, `flush`, `usi_en`, `if_en`: all 0.
- Reset mid-frame returns to IDLE on assertion. No `done` is issued.
- Let `start` be sampled at edge E0 (cycle 0), with N = `frame_len`:
  - RUN occupies cycles 1..N·UPS.
  - FLUSH occupies cycles N·UPS+1..N·UPS+FLUSH_CYC.
  - `done`=1 and `busy`=0 in cycle N·UPS+FLUSH_CYC+1.
- `start` in the `done` cycle is accepted. RUN begins in the next cycle, with no idle gap required.
- `usi_en` first asserts in cycle FILL_CYC+1. If the frame is shorter than that, `usi_en` never asserts.

## Configuration
- `QAM_TX_CTRL_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in RUN forces the transition to FLUSH at the next `ph`=UPS−1 boundary; the current symbol completes.
  - `abort` in FLUSH or IDLE has no effect.
- Not defined: no `abort` port. Frames always run to `frame_len`.

## Test plan
Defaults UPS=4, FILL_CYC=8, FLUSH_CYC=32 unless stated.
- Normal frame, N=3, `bit_vld`=1:
  - `bit_req` in cycles 1, 2, 5, 6, 9, 10.
  - `sym_en` in cycles 3, 7, 11, 15, 19, ….
  - `flush` in cycles 13..44.
  - `done` in cycle 45.
  - `usi_en` over cycles 9..44.
  - `underrun`=0.
- Mixer phase: `mix_phase` reads 0, 1, 2, 3, 0 in cycles 1..5. It holds its last value after `done`.
- Underrun: drop `bit_vld` in cycle 5 → `bit_zero`=1 in cycle 5; `underrun`=1 from cycle 6 through IDLE; the next `start` clears it.
- Boundary cases:
  - `start` with `frame_len`=0 → `busy` stays 0.
  - `start` during RUN → ignored; length unchanged.
  - `start` in the `done` cycle → `busy`=1 in the next cycle.
- Reset mid-frame: assert `rst` low in cycle 7 → all outputs 0 immediately; no `done`; a fresh frame then runs normally.
- With `QAM_TX_CTRL_ABORT_EN`: N=10, `abort` in cycle 6 → `flush` from cycle 9; `done` in cycle 41.
